// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the ysyx_23060187 core: GPR file state encoding and
// default register-file geometry used by decode and writeback.
package ysyx_23060187_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } gpr_state_e;

  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_DATA_WIDTH = 32;

endpackage

// File: rtl/ysyx_23060187_gpr_rdport.sv
// One combinational read port of the GPR file: zero masking during clear and
// for entry 0, plus optional same-cycle forwarding of the write port.
module ysyx_23060187_gpr_rdport
  import ysyx_23060187_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int BYPASS     = 1
) (
  input  gpr_state_e            state,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // raddr != 0 together with waddr == raddr already excludes a write to x0.
  always_comb begin
    rdata = '0;
    if (state == RUN && raddr != '0) begin
      if (BYPASS != 0 && wen && waddr == raddr) rdata = wdata;
      else                                     rdata = rf_data;
    end
  end

endmodule

// File: rtl/ysyx_23060187_gpr_file.sv
// Multi-port GPR file: reset-less storage array zeroed by a post-reset clear
// sequencer, one synchronous write port and NR_READ combinational read ports.
module ysyx_23060187_gpr_file
  import ysyx_23060187_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int NR_READ    = 2,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic                          ready,
  output logic [DATA_WIDTH-1:0]         gpr10
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  gpr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rf_q [DEPTH];

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_data;

  // The clear sequencer and the write port share the single array write path.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arr_we   = 1'b0;
    arr_addr = waddr;
    arr_data = wdata;
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          arr_we   = 1'b1;
          arr_addr = cnt_q;
          arr_data = '0;
          cnt_d    = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = RUN;
        end
        RUN: arr_we = wen && (waddr != '0);
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // No reset on the array so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (arr_we) rf_q[arr_addr] <= arr_data;
  end

  assign ready = (state_q == RUN);
  assign gpr10 = rf_q[A0_IDX];

  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    ysyx_23060187_gpr_rdport #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .BYPASS    (BYPASS)
    ) u_rdport (
      .state  (state_q),
      .raddr  (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .rf_data(rf_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]]),
      .wen    (wen),
      .waddr  (waddr),
      .wdata  (wdata),
      .rdata  (rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_ysyx_23060187_gpr_file.sv
// Bench for the GPR file: default build (A), no-bypass build (B) and a
// 3-port 16x64 build (C), driven on negedge and sampled 1ns later.
module tb_ysyx_23060187_gpr_file;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_wen, a_ready;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata, a_gpr10;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;

  logic        b_rst, b_wen, b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata, b_gpr10;
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;

  logic         c_rst, c_wen, c_ready;
  logic [3:0]   c_waddr;
  logic [63:0]  c_wdata, c_gpr10;
  logic [11:0]  c_raddr;
  logic [191:0] c_rdata;

  ysyx_23060187_gpr_file #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(a_rst), .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata),
    .raddr(a_raddr), .rdata(a_rdata), .ready(a_ready), .gpr10(a_gpr10));

  ysyx_23060187_gpr_file #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(b_rst), .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata),
    .raddr(b_raddr), .rdata(b_rdata), .ready(b_ready), .gpr10(b_gpr10));

  ysyx_23060187_gpr_file #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .NR_READ(3), .BYPASS(1)) dut_c (
    .clk(clk), .rst(c_rst), .wen(c_wen), .waddr(c_waddr), .wdata(c_wdata),
    .raddr(c_raddr), .rdata(c_rdata), .ready(c_ready), .gpr10(c_gpr10));

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  r0, r1;
    logic [31:0] e0, e1, eg;
  } vec_t;

  typedef struct {
    logic [31:0] e0, e1, eg;
  } exp_t;

  vec_t vecs [11];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    int   ra, rb, rc;
    exp_t e;

    // RUN-state vectors for build A; reads are checked in the same cycle as the write.
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd5,  5'd7,  32'hDEADBEEF, 32'hA5A5A5A5, 32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
    vecs[6]  = '{1'b1, 5'd7,  32'h00001111, 5'd7,  5'd3,  32'h00001111, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd7,  32'h0,        32'h00001111, 32'h0};
    vecs[8]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 5'd10, 32'h0000CAFE, 5'd10, 5'd31, 32'h0000CAFE, 32'hFFFFFFFF, 32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd1,  32'h0000CAFE, 32'h0,        32'h0000CAFE};

    a_rst = 1'b1; a_wen = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
    b_rst = 1'b1; b_wen = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
    c_rst = 1'b1; c_wen = 1'b0; c_waddr = '0; c_wdata = '0; c_raddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_raddr = {5'd3, 5'd10};
    #1;
    chk("rst_ready_a", {63'h0, a_ready}, 64'h0);
    chk("rst_rdata_a", a_rdata, 64'h0);
    chk("rst_ready_b", {63'h0, b_ready}, 64'h0);
    chk("rst_ready_c", {63'h0, c_ready}, 64'h0);

    // First clear on all three builds; bounded at 40 edges.
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    ra = 0; rb = 0; rc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 5) chk("clear_rd_mask", a_rdata, 64'h0);
      if (a_ready && ra == 0) ra = c;
      if (b_ready && rb == 0) rb = c;
      if (c_ready && rc == 0) rc = c;
    end
    chk("clear_len_a", 64'(ra), 64'd32);
    chk("clear_len_b", 64'(rb), 64'd32);
    chk("clear_len_c", 64'(rc), 64'd16);

    // Preload garbage, then reset while a write is offered.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      a_wen = 1'b1; a_waddr = 5'(i); a_wdata = 32'hBAD00000 | 32'(i);
    end
    @(negedge clk);
    a_wen = 1'b0;
    #1 chk("preload_gpr10", {32'h0, a_gpr10}, 64'hBAD0000A);
    a_rst = 1'b1; a_wen = 1'b1; a_waddr = 5'd5; a_wdata = 32'h77;
    @(negedge clk);
    a_wen = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
    chk("rst2_ready", {63'h0, a_ready}, 64'h0);

    // Clear with a write at edge 10 (x3) and at the RUN-entry edge 32 (x9): both dropped.
    ra = 0;
    for (int c = 1; c <= 40; c++) begin
      a_wen   = (c == 10) || (c == 32);
      a_waddr = (c == 10) ? 5'd3 : 5'd9;
      a_wdata = 32'h55;
      @(posedge clk); #1;
      if (a_ready && ra == 0) ra = c;
      @(negedge clk);
    end
    a_wen = 1'b0;
    chk("clear2_len", 64'(ra), 64'd32);
    for (int i = 0; i < 32; i++) begin
      a_raddr = {5'(i), 5'(i)};
      #1 chk($sformatf("cleared_x%0d", i), a_rdata, 64'h0);
    end
    chk("cleared_gpr10", {32'h0, a_gpr10}, 64'h0);

    // Table-driven RUN traffic through the scoreboard.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a_wen = vecs[i].wen; a_waddr = vecs[i].waddr; a_wdata = vecs[i].wdata;
      a_raddr = {vecs[i].r1, vecs[i].r0};
      sb.push_back('{vecs[i].e0, vecs[i].e1, vecs[i].eg});
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d_p0", i), {32'h0, a_rdata[31:0]}, {32'h0, e.e0});
      chk($sformatf("vec%0d_p1", i), {32'h0, a_rdata[63:32]}, {32'h0, e.e1});
      chk($sformatf("vec%0d_g10", i), {32'h0, a_gpr10}, {32'h0, e.eg});
    end
    @(negedge clk);
    a_wen = 1'b0;

    // Reset in RUN with a simultaneous write, then reset mid-clear at edge 20.
    a_rst = 1'b1; a_wen = 1'b1; a_waddr = 5'd7; a_wdata = 32'hEE; a_raddr = {5'd7, 5'd7};
    @(posedge clk); #1;
    chk("run_rst_ready", {63'h0, a_ready}, 64'h0);
    chk("run_rst_rdata", a_rdata, 64'h0);
    @(negedge clk);
    a_rst = 1'b0; a_wen = 1'b0;
    ra = 0;
    for (int c = 1; c <= 60; c++) begin
      a_rst = (c == 20);
      @(posedge clk); #1;
      if (a_ready && ra == 0) ra = c;
      @(negedge clk);
    end
    a_rst = 1'b0;
    chk("midclear_len", 64'(ra), 64'd52);
    #1 chk("midclear_x7", a_rdata, 64'h0);

    // No-bypass build: old value in the write cycle, new value after the edge.
    @(negedge clk);
    b_wen = 1'b1; b_waddr = 5'd7; b_wdata = 32'hA5A5A5A5; b_raddr = {5'd7, 5'd0};
    #1 chk("nobyp_same", b_rdata, 64'h0);
    @(negedge clk);
    b_wen = 1'b1; b_waddr = 5'd7; b_wdata = 32'h5A5A5A5A;
    #1 chk("nobyp_next", b_rdata, {32'hA5A5A5A5, 32'h0});
    @(negedge clk);
    b_wen = 1'b1; b_waddr = 5'd0; b_wdata = 32'h12345678; b_raddr = {5'd7, 5'd0};
    #1 chk("nobyp_x0", b_rdata, {32'h5A5A5A5A, 32'h0});
    @(negedge clk);
    b_wen = 1'b0;

    // 3-port 16x64 build.
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      c_wen = 1'b1; c_waddr = 4'(i); c_wdata = 64'h1111_0000_0000_0000 * 64'(i) + 64'(i);
    end
    @(negedge clk);
    c_wen = 1'b1; c_waddr = 4'd10; c_wdata = 64'h1;
    #1 chk("c_gpr10_nobyp", c_gpr10, 64'h0);
    @(negedge clk);
    c_wen = 1'b0; c_raddr = {4'd3, 4'd1, 4'd2};
    #1;
    chk("c_gpr10", c_gpr10, 64'h1);
    chk("c_p0", c_rdata[63:0],    64'h2222_0000_0000_0002);
    chk("c_p1", c_rdata[127:64],  64'h1111_0000_0000_0001);
    chk("c_p2", c_rdata[191:128], 64'h3333_0000_0000_0003);
    @(negedge clk);
    c_wen = 1'b1; c_waddr = 4'd15; c_wdata = 64'hFEED; c_raddr = {4'd15, 4'd0, 4'd15};
    #1 chk("c_byp", c_rdata, {64'hFEED, 64'h0, 64'hFEED});
    @(negedge clk);
    c_wen = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_23060187_gpr_file.md
# ysyx_23060187_gpr_file

Multi-port general-purpose register file for the ysyx_23060187 core. Provides a parametrised number of combinational read ports, one synchronous write port, a hardwired-zero entry 0, and optional same-cycle write-to-read bypass. A self-clearing sequencer zeroes every entry after reset, so the array can still map to reset-less memory. Sits between decode (operand reads) and writeback (result write). Entry 10 (a0) is exported for the simulation halt/return-code path.

## Interface

- Clocking: one clock; reset is synchronous and active-high.
- Parameters:
  - ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries
  - DATA_WIDTH, 32, bits per entry
  - NR_READ, 2, number of read ports (≥1)
  - BYPASS, 1, 1 = write data forwarded to matching read ports in the same cycle
- Ports:
  - clk  input  1  clock, all state updates on rising edge
  - rst  input  1  synchronous active-high reset
  - wen  input  1  write enable
  - waddr  input  ADDR_WIDTH  write address
  - wdata  input  DATA_WIDTH  write data
  - raddr  input  NR_READ*ADDR_WIDTH  packed read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
  - rdata  output  NR_READ*DATA_WIDTH  packed read data, same packing
  - ready  output  1  1 = clear finished, file accepts writes
  - gpr10  output  DATA_WIDTH  current contents of entry 10, no bypass

## Operation

- FSM states: CLEAR, RUN.
  - rst=1 at an edge: state←CLEAR, clear counter cnt←0. No array writes on that edge.
  - CLEAR with rst=0: rf[cnt]←0, cnt←cnt+1. When cnt==DEPTH-1: state←RUN.
  - RUN: stays RUN until rst.
- ready = (state==RUN), driven from the registered state.
- Writes: in RUN, wen=1 and waddr≠0 → rf[waddr]←wdata at the edge. Writes in CLEAR are dropped, not queued. Writes to address 0 are always dropped.
- Reads, per port i, combinational:
  - CLEAR: rdata_i = 0.
  - raddr_i == 0: rdata_i = 0.
  - BYPASS=1, RUN, wen=1, waddr==raddr_i, waddr≠0: rdata_i = wdata.
  - Otherwise: rdata_i = rf[raddr_i].
- Several read ports may use the same address. Each resolves independently with identical results.
- gpr10 = rf[10], with no bypass and no CLEAR masking. After clear it reads 0.
- Out-of-range conditions cannot occur: addresses span DEPTH exactly and cnt wraps only at the RUN transition.

## Timing

- Reset values: state=CLEAR, cnt=0, ready=0, and every rdata port reads 0 while in CLEAR.
- Clear length: ready rises exactly DEPTH rising edges after the first edge with rst=0. ADDR_WIDTH=5 → 32 cycles.
- Write latency: 1 edge. Without bypass, a read of the written address shows the new value in the cycle after the edge. With BYPASS=1 it shows in the same cycle.
- Read latency: 0 cycles (combinational).
- rst asserted mid-clear: the next edge restarts at cnt=0, and the full DEPTH-cycle clear repeats.
- rst asserted in RUN: any simultaneous write is dropped. Contents are zeroed again by the new clear.
- wen=1 on the edge where the FSM enters RUN is dropped, because state was still CLEAR on that edge.

## Structure

- Shared package ysyx_23060187_pkg holds:
  - the state encoding (CLEAR=1'b0, RUN=1'b1)
  - default ADDR_WIDTH/DATA_WIDTH constants used by decode and writeback
- Sub-module ysyx_23060187_gpr_rdport holds one read port's mux and bypass logic. It is instantiated NR_READ times in a generate loop.
- The array, clear FSM and write logic stay in the top module.

## Test plan

1. Reset clear:
   - Preload garbage (force), rst=1 for 2 cycles, then release.
   - ready=0 for exactly 32 cycles, then 1.
   - All 32 entries read 0 on every port; gpr10=0.
2. Basic write/read:
   - In RUN, write 0xDEADBEEF to x5.
   - Next cycle, raddr port0=5 and port1=5 both read 0xDEADBEEF.
3. Zero register:
   - Write 0x12345678 to x0.
   - Reads of x0 return 0 on all ports, including the bypass cycle.
4. Bypass:
   - BYPASS=1: wen=1, waddr=7, wdata=0xA5A5A5A5, raddr port1=7 → port1 reads 0xA5A5A5A5 in the same cycle.
   - BYPASS=0 build: the same stimulus returns the old value that cycle and the new value the next cycle.
5. Write during clear and reset mid-clear:
   - Write x3=0x55 at clear cycle 4 → x3 reads 0 after ready.
   - Pulse rst at clear cycle 20 → ready rises 32 cycles after that release.
6. Parameter sweep with gpr10:
   - NR_READ=3, ADDR_WIDTH=4, DATA_WIDTH=64: ready after 16 cycles.
   - Write x10=0x1 → gpr10=0x1 on the next cycle.
   - Three independent ports each read distinct written values correctly.
